// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage, one outstanding imem fetch, 1-entry skid buffer, redirect kill of in-flight responses.
// Define FETCH_PERF_EN to add the bubble_cnt performance counter port.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_F,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_F,
  output logic [31:0] pcplus4_F,
  output logic        valid_F
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] bubble_cnt
`endif
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d, skid_pc4_q, skid_pc4_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        kill_q, kill_d, skid_v_q, skid_v_d, valid_q, valid_d;
  logic        out_free, resp_ok;
  assign out_free = !valid_q || !stall_F;
  assign resp_ok  = imem_rvalid && !kill_q && !redirect_en;
  always_ff @(posedge clk) state_q <= reset ? S_REQ : state_d;
  // A redirect in S_WAIT stays put: the killed response must still drain.
  always_comb begin
    state_d = state_q;
    if (state_q == S_REQ)
      state_d = imem_gnt ? S_WAIT : S_REQ;
    else if (state_q == S_WAIT)
      state_d = !imem_rvalid ? S_WAIT : (resp_ok && !out_free) ? S_FULL : S_REQ;
    else
      state_d = (!stall_F || redirect_en) ? S_REQ : S_FULL;
  end
  always_comb begin
    imem_req  = state_q == S_REQ && !skid_v_q && !reset;
    imem_addr = pc_q;
  end
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    kill_d       = kill_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    skid_v_d     = skid_v_q;
    valid_d      = valid_q && stall_F;
    instr_d      = stall_F ? instr_q : '0;
    pc4_d        = pc4_q;
    if (state_q == S_REQ && imem_gnt) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + 32'd4;
      kill_d   = redirect_en;
    end
    if (state_q == S_WAIT)
      kill_d = !imem_rvalid && (kill_q || redirect_en);
    if (state_q == S_WAIT && resp_ok && out_free)
      {valid_d, instr_d, pc4_d} = {1'b1, imem_rdata, req_pc_q + 32'd4};
    if (state_q == S_WAIT && resp_ok && !out_free)
      {skid_v_d, skid_instr_d, skid_pc4_d} = {1'b1, imem_rdata, req_pc_q + 32'd4};
    if (state_q == S_FULL && !stall_F) begin
      {valid_d, instr_d, pc4_d} = {1'b1, skid_instr_q, skid_pc4_q};
      skid_v_d = 1'b0;
    end
    if (redirect_en) begin
      pc_d     = redirect_pc;
      valid_d  = 1'b0;
      instr_d  = '0;
      skid_v_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      kill_q       <= 1'b0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      skid_v_q     <= 1'b0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      kill_q       <= kill_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      skid_v_q     <= skid_v_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end
  assign instr_F   = instr_q;
  assign pcplus4_F = pc4_q;
  assign valid_F   = valid_q;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_q;
  always_ff @(posedge clk) bubble_q <= reset ? '0 : bubble_q + {31'b0, !valid_q && !stall_F};
  assign bubble_cnt = bubble_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios then randomized stall/redirect/grant/latency traffic checked against
// a program-order model of fetched instructions and a one-outstanding memory responder.
module tb_fetch_stage;
  localparam logic [31:0] RP = 32'h0000_0040;
  logic        clk = 0, reset = 1, stall_F = 0, redirect_en = 0, gnt_en = 1;
  logic [31:0] redirect_pc = 0;
  logic        imem_req, imem_gnt, imem_rvalid = 0, valid_F;
  logic [31:0] imem_addr, imem_rdata = 0, instr_F, pcplus4_F;
  int          checks = 0, failures = 0, ndeliv = 0, lat_lo = 1, lat_hi = 1, mem_cnt = 0;
  logic        mem_busy = 0, prev_red = 0, prev_hold = 0;
  logic [31:0] mem_addr = 0, exp_pc = RP, req_exp = RP, hold_pc4 = 0, hold_instr = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt, exp_bub = 0;
`endif

  always #5 clk = ~clk;
  assign imem_gnt = imem_req && gnt_en;

  fetch_stage #(.RESET_PC(RP)) dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_F(instr_F), .pcplus4_F(pcplus4_F), .valid_F(valid_F)
`ifdef FETCH_PERF_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h2008_0005 : a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs, advance the model across the edge, then drive the memory response.
  task automatic tick();
    logic fire, deliv;
    #1;
    fire  = !reset && imem_req && imem_gnt;
    deliv = !reset && valid_F && !stall_F && !redirect_en;
    if (reset) check("req_in_reset", 32'(imem_req), 32'd0);
    else begin
      if (!valid_F) check("nop_when_invalid", instr_F, 32'd0);
      if (mem_busy) check("one_outstanding", 32'(imem_req), 32'd0);
      if (prev_red) check("flush_after_redirect", 32'(valid_F), 32'd0);
      if (prev_hold) begin
        check("hold_valid", 32'(valid_F), 32'd1);
        check("hold_pc4", pcplus4_F, hold_pc4);
        check("hold_instr", instr_F, hold_instr);
      end
      if (fire) check("req_addr", imem_addr, req_exp);
      if (deliv) begin
        check("deliv_pc4", pcplus4_F, exp_pc + 32'd4);
        check("deliv_instr", instr_F, mem_word(exp_pc));
      end
`ifdef FETCH_PERF_EN
      check("bubble_cnt", bubble_cnt, exp_bub);
`endif
    end
    if (reset) begin
      mem_busy = 0; exp_pc = RP; req_exp = RP; prev_red = 0; prev_hold = 0;
`ifdef FETCH_PERF_EN
      exp_bub = 0;
`endif
    end else begin
      if (imem_rvalid) mem_busy = 0;
      if (fire) begin
        mem_busy = 1; mem_addr = imem_addr; req_exp = imem_addr + 32'd4;
        mem_cnt = int'($urandom_range(lat_hi, lat_lo));
      end
      if (deliv) begin exp_pc = exp_pc + 32'd4; ndeliv++; end
`ifdef FETCH_PERF_EN
      if (!valid_F && !stall_F) exp_bub = exp_bub + 32'd1;
`endif
      if (redirect_en) begin exp_pc = redirect_pc; req_exp = redirect_pc; end
      prev_red   = redirect_en;
      prev_hold  = valid_F && stall_F && !redirect_en;
      hold_pc4   = pcplus4_F;
      hold_instr = instr_F;
    end
    @(posedge clk);
    #1;
    if (mem_busy) mem_cnt--;
    imem_rvalid = mem_busy && mem_cnt == 0;
    imem_rdata  = imem_rvalid ? mem_word(mem_addr) : 32'hDEAD_BEEF;
  endtask

  initial begin
    repeat (3) tick();
    reset = 0;
    #1;
    check("t1_req", 32'(imem_req), 32'd1);
    check("t1_addr", imem_addr, 32'h40);
    tick();
    check("t1_wait_noreq", 32'(imem_req), 32'd0);
    tick();
    check("t1_valid", 32'(valid_F), 32'd1);
    check("t1_instr", instr_F, 32'h2008_0005);
    check("t1_pc4", pcplus4_F, 32'h44);
    check("t1_next_req", 32'(imem_req), 32'd1);
    check("t1_next_addr", imem_addr, 32'h44);
    stall_F = 1;
    tick();
    tick();
    check("t2_skid_noreq", 32'(imem_req), 32'd0);
    check("t2_held_valid", 32'(valid_F), 32'd1);
    check("t2_held_pc4", pcplus4_F, 32'h44);
    tick();
    check("t2_still_noreq", 32'(imem_req), 32'd0);
    stall_F = 0;
    tick();
    check("t2_skid_pc4", pcplus4_F, 32'h48);
    check("t2_skid_instr", instr_F, mem_word(32'h44));
    check("t2_new_req", 32'(imem_req), 32'd1);
    check("t2_new_addr", imem_addr, 32'h48);
    lat_lo = 3; lat_hi = 3;
    tick();
    redirect_en = 1; redirect_pc = 32'h100;
    tick();
    redirect_en = 0;
    check("t3_flush_valid", 32'(valid_F), 32'd0);
    check("t3_wait_noreq", 32'(imem_req), 32'd0);
    tick();
    check("t3_still_waiting", 32'(imem_req), 32'd0);
    tick();
    check("t3_discarded", 32'(valid_F), 32'd0);
    check("t3_target_req", 32'(imem_req), 32'd1);
    check("t3_target_addr", imem_addr, 32'h100);
    lat_lo = 1; lat_hi = 1;
    stall_F = 1;
    tick();
    tick();
    check("t4_out_valid", 32'(valid_F), 32'd1);
    check("t4_out_pc4", pcplus4_F, 32'h104);
    check("t4_req_addr", imem_addr, 32'h104);
    tick();
    tick();
    check("t4_full_noreq", 32'(imem_req), 32'd0);
    redirect_en = 1; redirect_pc = 32'h200;
    tick();
    redirect_en = 0; stall_F = 0;
    check("t4_flush_valid", 32'(valid_F), 32'd0);
    check("t4_flush_instr", instr_F, 32'd0);
    check("t4_target_req", 32'(imem_req), 32'd1);
    check("t4_target_addr", imem_addr, 32'h200);
    tick();
    tick();
    check("t4_target_valid", 32'(valid_F), 32'd1);
    check("t4_target_pc4", pcplus4_F, 32'h204);
    check("t4_target_instr", instr_F, mem_word(32'h200));
    gnt_en = 0; redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_en = 0; gnt_en = 1;
    check("t5_req", 32'(imem_req), 32'd1);
    check("t5_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("t5_valid", 32'(valid_F), 32'd1);
    check("t5_pc4_wrap", pcplus4_F, 32'd0);
    check("t5_instr", instr_F, mem_word(32'hFFFF_FFFC));
    check("t5_next_addr", imem_addr, 32'd0);
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      stall_F     = $urandom_range(9, 0) < 3;
      redirect_en = $urandom_range(24, 0) == 0;
      redirect_pc = $urandom_range(1, 0) == 0 ? $urandom() : 32'hFFFF_FFF4;
      gnt_en      = $urandom_range(9, 0) < 7;
      reset       = $urandom_range(399, 0) == 0;
      tick();
    end
    check("liveness", 32'(ndeliv >= 150), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
